memory_stage: RTL and testbench

//  MEM stage of the 5-stage MIPS pipeline, directly downstream of EXECUTE. Consumes the EX/MEM

---
 rtl/memory_stage.sv | 145 ++++++++++++++
 tb/tb_memory_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : memory_stage                                                    |
// | Purpose  : MEM stage of a 5-stage MIPS pipeline. Issues data-memory        |
// |            requests, stalls upstream while an access is outstanding,       |
// |            holds the MEM/WB pipeline register (also used for forwarding    |
// |            back to EXECUTE) and resolves branch/jump (PCSrc).              |
// | Ports    : CLK, RST (async, active-low)                                    |
// |            EX/MEM in : branch, jump, MemRead, MemWrite, RegWrite,          |
// |                        MemtoReg, alu_out, readdata2_out, muxRegDst_out     |
// |            dmem      : dmem_req/we/addr/wdata out, dmem_rdata/ack in       |
// |            control   : stall, PCSrc, mem_err (sticky)                      |
// |            MEM/WB    : regMemWb, WBRegRd_wire, WB_RegWrite_wire            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module memory_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              branch,
  input  logic              jump,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] readdata2_out,
  input  logic [REG_W-1:0]  muxRegDst_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall,
  output logic              PCSrc,
  output logic              mem_err,
  output logic [DATA_W-1:0] regMemWb,
  output logic [REG_W-1:0]  WBRegRd_wire,
  output logic              WB_RegWrite_wire
);

  localparam int c_CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_mem_err;
  logic [DATA_W-1:0]   r_wb_data;
  logic [REG_W-1:0]    r_wb_rd;
  logic                r_wb_we;

  logic w_memop;
  logic w_misalign;
  logic w_conflict;
  logic w_req;
  logic w_timeout;
  logic w_stall;
  logic w_done;

  assign w_memop    = MemRead | MemWrite;
  assign w_misalign = w_memop & (alu_out[1:0] != 2'b00);
  assign w_conflict = MemRead & MemWrite;
  // RST gating makes the request vanish the moment reset is asserted,
  // abandoning any access in flight without waiting for a clock edge.
  assign w_req      = RST & w_memop & ~w_misalign;
  // The final wait cycle is the abort cycle: stall drops so the pipeline
  // advances past the failed access on this edge.
  assign w_timeout  = (r_state == S_ACCESS) & w_req & ~dmem_ack & (r_cnt == c_CNT_LAST);
  assign w_stall    = w_req & ~dmem_ack & ~w_timeout;
  assign w_done     = w_req & dmem_ack;

  assign dmem_req         = w_req;
  // A read+write conflict is carried out as a write.
  assign dmem_we          = w_req & MemWrite;
  assign dmem_addr        = alu_out;
  assign dmem_wdata       = readdata2_out;
  assign stall            = w_stall;
  assign PCSrc            = (branch & alu_out[0]) | jump;
  assign mem_err          = r_mem_err;
  assign regMemWb         = r_wb_data;
  assign WBRegRd_wire     = r_wb_rd;
  assign WB_RegWrite_wire = r_wb_we;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
      r_wb_data <= '0;
      r_wb_rd   <= '0;
      r_wb_we   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_stall) begin
            r_state <= S_ACCESS;
            r_cnt   <= '0;
          end
        end
        S_ACCESS: begin
          if (w_stall) begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end else begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase

      if (w_timeout | w_misalign | w_conflict) begin
        r_mem_err <= 1'b1;
      end

      // MEM/WB register: bubble on stall, suppress write on a failed access,
      // otherwise load the completed instruction.
      if (w_stall || w_timeout || w_misalign) begin
        r_wb_we <= 1'b0;
      end else if (w_done) begin
        r_wb_data <= (MemtoReg & ~MemWrite) ? dmem_rdata : alu_out;
        r_wb_rd   <= muxRegDst_out;
        r_wb_we   <= RegWrite;
      end else begin
        r_wb_data <= alu_out;
        r_wb_rd   <= muxRegDst_out;
        r_wb_we   <= RegWrite;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_memory_stage                                                 |
// | Purpose  : Directed self-checking bench for memory_stage.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_memory_stage;

  logic        CLK;
  logic        RST;
  logic        branch, jump, MemRead, MemWrite, RegWrite, MemtoReg;
  logic [31:0] alu_out, readdata2_out, dmem_rdata;
  logic [4:0]  muxRegDst_out;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall, PCSrc, mem_err, WB_RegWrite_wire;
  logic [31:0] dmem_addr, dmem_wdata, regMemWb;
  logic [4:0]  WBRegRd_wire;

  int n_vec = 0;
  int n_err = 0;

  memory_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYC(16)) dut (
    .CLK(CLK), .RST(RST),
    .branch(branch), .jump(jump), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .alu_out(alu_out), .readdata2_out(readdata2_out), .muxRegDst_out(muxRegDst_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .PCSrc(PCSrc), .mem_err(mem_err),
    .regMemWb(regMemWb), .WBRegRd_wire(WBRegRd_wire), .WB_RegWrite_wire(WB_RegWrite_wire)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    branch = 0; jump = 0; MemRead = 0; MemWrite = 0; RegWrite = 0; MemtoReg = 0;
    alu_out = 0; readdata2_out = 0; muxRegDst_out = 0; dmem_rdata = 0; dmem_ack = 0;
  endtask

  task automatic pulse_reset();
    RST = 1'b0;
    #2;
    RST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    MemRead = 1; alu_out = 32'h10; // would request if not in reset
    RST = 1'b0;
    #3;
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", mem_err); end
    n_vec++; if (regMemWb !== 32'h0) begin n_err++; $display("FAIL reset_wbdata got=%h exp=0", regMemWb); end
    n_vec++; if (WB_RegWrite_wire !== 1'b0) begin n_err++; $display("FAIL reset_wbwe got=%b exp=0", WB_RegWrite_wire); end
    clear_inputs();
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic test_rtype();
    clear_inputs();
    alu_out = 32'd3; muxRegDst_out = 5'd5; RegWrite = 1;
    #1;
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rtype_req got=%b exp=0", dmem_req); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rtype_stall got=%b exp=0", stall); end
    tick();
    n_vec++; if (regMemWb !== 32'd3) begin n_err++; $display("FAIL rtype_wbdata got=%h exp=3", regMemWb); end
    n_vec++; if (WBRegRd_wire !== 5'd5) begin n_err++; $display("FAIL rtype_rd got=%0d exp=5", WBRegRd_wire); end
    n_vec++; if (WB_RegWrite_wire !== 1'b1) begin n_err++; $display("FAIL rtype_wbwe got=%b exp=1", WB_RegWrite_wire); end
  endtask

  task automatic test_load_fast();
    clear_inputs();
    MemRead = 1; MemtoReg = 1; RegWrite = 1; alu_out = 32'h10; muxRegDst_out = 5'd8;
    dmem_rdata = 32'h0000CAFE; dmem_ack = 1;
    #1;
    n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL ldfast_req got=%b exp=1", dmem_req); end
    n_vec++; if (dmem_we !== 1'b0) begin n_err++; $display("FAIL ldfast_we got=%b exp=0", dmem_we); end
    n_vec++; if (dmem_addr !== 32'h10) begin n_err++; $display("FAIL ldfast_addr got=%h exp=10", dmem_addr); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL ldfast_stall got=%b exp=0", stall); end
    tick();
    n_vec++; if (regMemWb !== 32'h0000CAFE) begin n_err++; $display("FAIL ldfast_wbdata got=%h exp=cafe", regMemWb); end
    n_vec++; if (WBRegRd_wire !== 5'd8) begin n_err++; $display("FAIL ldfast_rd got=%0d exp=8", WBRegRd_wire); end
    n_vec++; if (WB_RegWrite_wire !== 1'b1) begin n_err++; $display("FAIL ldfast_wbwe got=%b exp=1", WB_RegWrite_wire); end
  endtask

  task automatic test_store_slow();
    clear_inputs();
    MemWrite = 1; alu_out = 32'h20; readdata2_out = 32'd7; muxRegDst_out = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL st_req[%0d] got=%b exp=1", i, dmem_req); end
      n_vec++; if (dmem_we !== 1'b1) begin n_err++; $display("FAIL st_we[%0d] got=%b exp=1", i, dmem_we); end
      n_vec++; if (dmem_wdata !== 32'd7) begin n_err++; $display("FAIL st_wdata[%0d] got=%h exp=7", i, dmem_wdata); end
      n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL st_stall[%0d] got=%b exp=1", i, stall); end
      tick();
      n_vec++; if (WB_RegWrite_wire !== 1'b0) begin n_err++; $display("FAIL st_bubble[%0d] got=%b exp=0", i, WB_RegWrite_wire); end
      n_vec++; if (regMemWb !== 32'h0000CAFE) begin n_err++; $display("FAIL st_hold[%0d] got=%h exp=cafe", i, regMemWb); end
    end
    dmem_ack = 1;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL st_release got=%b exp=0", stall); end
    tick();
    n_vec++; if (regMemWb !== 32'h20) begin n_err++; $display("FAIL st_wbdata got=%h exp=20", regMemWb); end
    n_vec++; if (WBRegRd_wire !== 5'd9) begin n_err++; $display("FAIL st_rd got=%0d exp=9", WBRegRd_wire); end
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL st_err got=%b exp=0", mem_err); end
    clear_inputs();
    #1;
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL st_idle_req got=%b exp=0", dmem_req); end
  endtask

  task automatic test_branch();
    clear_inputs();
    branch = 1; alu_out = 32'd1; RegWrite = 1; muxRegDst_out = 5'd2;
    #1;
    n_vec++; if (PCSrc !== 1'b1) begin n_err++; $display("FAIL beq_taken got=%b exp=1", PCSrc); end
    alu_out = 32'd0;
    #1;
    n_vec++; if (PCSrc !== 1'b0) begin n_err++; $display("FAIL beq_not_taken got=%b exp=0", PCSrc); end
    branch = 0; jump = 1;
    #1;
    n_vec++; if (PCSrc !== 1'b1) begin n_err++; $display("FAIL jump got=%b exp=1", PCSrc); end
    tick();
    n_vec++; if (WB_RegWrite_wire !== 1'b1) begin n_err++; $display("FAIL br_wbwe got=%b exp=1", WB_RegWrite_wire); end
  endtask

  task automatic test_misalign();
    clear_inputs();
    MemRead = 1; MemtoReg = 1; RegWrite = 1; alu_out = 32'h22; muxRegDst_out = 5'd6;
    #1;
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL mis_req got=%b exp=0", dmem_req); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mis_stall got=%b exp=0", stall); end
    tick();
    n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL mis_err got=%b exp=1", mem_err); end
    n_vec++; if (WB_RegWrite_wire !== 1'b0) begin n_err++; $display("FAIL mis_wbwe got=%b exp=0", WB_RegWrite_wire); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int n_stall;
    clear_inputs();
    pulse_reset();
    tick();
    alu_out = 32'd9; muxRegDst_out = 5'd3; RegWrite = 1;
    tick();
    clear_inputs();
    MemRead = 1; MemtoReg = 1; RegWrite = 1; alu_out = 32'h30; muxRegDst_out = 5'd4;
    #1;
    n_stall = 0;
    while (stall === 1'b1 && n_stall < 40) begin
      n_stall++;
      tick();
    end
    n_vec++; if (n_stall !== 16) begin n_err++; $display("FAIL to_stall_cycles got=%0d exp=16", n_stall); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL to_stall_drop got=%b exp=0", stall); end
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL to_err_early got=%b exp=0", mem_err); end
    tick();
    n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL to_err got=%b exp=1", mem_err); end
    n_vec++; if (WB_RegWrite_wire !== 1'b0) begin n_err++; $display("FAIL to_wbwe got=%b exp=0", WB_RegWrite_wire); end
    n_vec++; if (regMemWb !== 32'd9) begin n_err++; $display("FAIL to_hold got=%h exp=9", regMemWb); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_in_access();
    clear_inputs();
    alu_out = 32'h55; muxRegDst_out = 5'd4; RegWrite = 1;
    tick();
    n_vec++; if (regMemWb !== 32'h55) begin n_err++; $display("FAIL rst_pre_wbdata got=%h exp=55", regMemWb); end
    clear_inputs();
    MemRead = 1; MemtoReg = 1; RegWrite = 1; alu_out = 32'h40;
    tick();
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst_access_stall got=%b exp=1", stall); end
    RST = 1'b0;
    #1;
    n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%b exp=0", stall); end
    n_vec++; if (WB_RegWrite_wire !== 1'b0) begin n_err++; $display("FAIL rst_wbwe got=%b exp=0", WB_RegWrite_wire); end
    n_vec++; if (regMemWb !== 32'h0) begin n_err++; $display("FAIL rst_wbdata got=%h exp=0", regMemWb); end
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", mem_err); end
    clear_inputs();
    #1;
    RST = 1'b1;
    tick();
  endtask

  task automatic test_conflict();
    clear_inputs();
    MemRead = 1; MemWrite = 1; alu_out = 32'h44; readdata2_out = 32'h11; dmem_ack = 1;
    #1;
    n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL cf_req got=%b exp=1", dmem_req); end
    n_vec++; if (dmem_we !== 1'b1) begin n_err++; $display("FAIL cf_we got=%b exp=1", dmem_we); end
    n_vec++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL cf_err_early got=%b exp=0", mem_err); end
    tick();
    n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL cf_err got=%b exp=1", mem_err); end
    clear_inputs();
    tick();
    n_vec++; if (mem_err !== 1'b1) begin n_err++; $display("FAIL cf_sticky got=%b exp=1", mem_err); end
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    #2;
    test_reset();
    test_rtype();
    test_load_fast();
    test_store_slow();
    test_branch();
    test_misalign();
    test_timeout();
    test_reset_in_access();
    test_conflict();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
